dv_trace_merge: RTL

- Sits between the dut and the trace writer. Captures the dut sample stream (dut_sready/dut_sample) and control read-back stream (dut_cready/dut_addr/dut_data) each cycle.
- Merges them into one time-stamped record per active cycle and buffers records in a FIFO.
- The trace writer drains records with a valid/ready handshake, so bursts from the dut are absorbed while trace output is stalled.
- Overflow is counted, never silently hidden.

---
 rtl/dv_trace_merge.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dv_trace_merge.sv
// -----------------------------------------------------------------------------
// dv_trace_merge
//
// Merges the dut sample stream and the control read-back stream into one
// time-stamped record per active cycle. Records are held in a
// first-word-fall-through FIFO and drained by the trace writer with a
// valid/ready handshake. When the FIFO is full and cannot pop, new records
// are dropped and counted in a saturating overflow counter.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   dut_sready        sample valid this cycle
//   dut_sample        sample value (SW bits)
//   dut_cready        control read-back valid this cycle
//   dut_addr          control address (AW bits)
//   dut_data          control data (DW bits)
//   flush             synchronous FIFO clear
//   trace_ready       downstream accepts the head record
//   trace_valid       head record available
//   trace_kind        bit0 = sample present, bit1 = control present
//   trace_stamp       cycle stamp of head record
//   trace_sample      sample field of head record
//   trace_addr        address field of head record
//   trace_data        data field of head record
//   fifo_count        entries held, 0..DEPTH
//   overflow_count    records dropped, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module dv_trace_merge #(
  parameter int SW    = 16,
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int PW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dut_sready,
  input  logic [SW-1:0] dut_sample,
  input  logic          dut_cready,
  input  logic [AW-1:0] dut_addr,
  input  logic [DW-1:0] dut_data,
  input  logic          flush,
  input  logic          trace_ready,
  output logic          trace_valid,
  output logic [1:0]    trace_kind,
  output logic [31:0]   trace_stamp,
  output logic [SW-1:0] trace_sample,
  output logic [AW-1:0] trace_addr,
  output logic [DW-1:0] trace_data,
  output logic [PW:0]   fifo_count,
  output logic [15:0]   overflow_count
);

  // Record layout, MSB first: kind, stamp, sample, addr, data.
  localparam int RW = 2 + 32 + SW + AW + DW;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0] CNT_ONE = {{PW{1'b0}}, 1'b1};

  logic [31:0]   stamp_r;
  logic [RW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic [15:0]   ovf_r;

  logic [RW-1:0] rec_s;
  logic [RW-1:0] head_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          wr_en_s;
  logic          drop_s;
  logic          valid_s;

  // Build the merged record; fields of absent streams are forced to zero.
  always_comb begin
    rec_s = {RW{1'b0}};
    rec_s[RW-1 -: 2]  = {dut_cready, dut_sready};
    rec_s[RW-3 -: 32] = stamp_r;
    if (dut_sready) begin
      rec_s[SW+AW+DW-1 -: SW] = dut_sample;
    end else begin
      rec_s[SW+AW+DW-1 -: SW] = {SW{1'b0}};
    end
    if (dut_cready) begin
      rec_s[AW+DW-1 -: AW] = dut_addr;
      rec_s[DW-1:0]        = dut_data;
    end else begin
      rec_s[AW+DW-1 -: AW] = {AW{1'b0}};
      rec_s[DW-1:0]        = {DW{1'b0}};
    end
  end

  // Push/pop qualification. Flush suppresses both so the clear wins.
  always_comb begin
    valid_s = (count_r != {(PW+1){1'b0}});
    full_s  = (count_r == DEPTH_C);
    push_s  = (dut_sready | dut_cready) & ~flush;
    pop_s   = valid_s & trace_ready & ~flush;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    wr_en_s = push_s & (~full_s | pop_s);
    drop_s  = push_s & full_s & ~pop_s;
  end

  // Free-running cycle stamp; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      stamp_r <= 32'd0;
    end else begin
      stamp_r <= stamp_r + 32'd1;
    end
  end

  // Record storage: registered write, no reset so it can map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_r[wr_ptr_r] <= rec_s;
    end
  end

  // Pointers and explicit occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (wr_en_s && !pop_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (pop_s && !wr_en_s) begin
        count_r <= count_r - CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Saturating count of dropped records; flush does not touch it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r <= 16'd0;
    end else if (drop_s && (ovf_r != 16'hFFFF)) begin
      ovf_r <= ovf_r + 16'd1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Head entry, masked to zero while the FIFO is empty so stale storage
  // never reaches the outputs.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (!valid_s) begin
      head_s = {RW{1'b0}};
    end else begin
      head_s = mem_r[rd_ptr_r];
    end
  end

  assign trace_valid    = valid_s;
  assign trace_kind     = head_s[RW-1 -: 2];
  assign trace_stamp    = head_s[RW-3 -: 32];
  assign trace_sample   = head_s[SW+AW+DW-1 -: SW];
  assign trace_addr     = head_s[AW+DW-1 -: AW];
  assign trace_data     = head_s[DW-1:0];
  assign fifo_count     = count_r;
  assign overflow_count = ovf_r;

endmodule
